// File: rtl/mc_pkg.sv
// mc_pkg: shared encodings for the multicycle MIPS control path.
// Holds the opcode and funct constants, the control FSM state encoding,
// the ALUOp codes and the select encodings for the ALUSrcB, PCSource,
// MemtoReg and RegDst muxes. The ALU control block and the datapath
// muxes import the same package, so all of them agree on these values.
package mc_pkg;

  // Primary opcodes (IR[31:26]) and the one funct code that matters here
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FUNCT_JR = 6'b001000;

  // Control FSM states; the numeric values are visible on the debug port
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTEXEC  = 4'd6,
    S_RTWB    = 4'd7,
    S_BRANCH  = 4'd8,
    S_IMMEXEC = 4'd9,
    S_IMMWB   = 4'd10,
    S_JUMP    = 4'd11,
    S_JR      = 4'd12,
    S_LUI     = 4'd13,
    S_TRAP    = 4'd14,
    S_UNUSED  = 4'd15
  } stateT;

  // ALUOp codes handed to the ALU control block
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_OR    = 4'b0010;
  localparam logic [3:0] ALU_AND   = 4'b0011;
  localparam logic [3:0] ALU_RTYPE = 4'b0111;

  // ALU B operand select
  localparam logic [2:0] SRCB_B        = 3'd0;
  localparam logic [2:0] SRCB_FOUR     = 3'd1;
  localparam logic [2:0] SRCB_SIGNEXT  = 3'd2;
  localparam logic [2:0] SRCB_SIGNSHL2 = 3'd3;
  localparam logic [2:0] SRCB_ZEROEXT  = 3'd4;

  // ALU A operand select
  localparam logic SRCA_PC = 1'b0;
  localparam logic SRCA_A  = 1'b1;

  // Next-PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_RS     = 2'd3;

  // Register file write-data select
  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_MDR    = 2'd1;
  localparam logic [1:0] M2R_PC     = 2'd2;
  localparam logic [1:0] M2R_LUI    = 2'd3;

  // Register file write-address select
  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

endpackage

// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM of the multicycle MIPS core.
// Sequences the shared memory port, the ALU and the holding registers
// through fetch/decode/execute/memory/writeback, traps illegal opcodes
// and counts retired instructions.
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   OP, Funct           IR[31:26] and IR[5:0], stable from DECODE onward
//   MemReady            memory finishes the current access this cycle
//   PCWrite, BranchEQ, BranchNE, IorD, MemRead, MemWrite, IRWrite,
//   RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource
//                       datapath control strobes and mux selects
//   State               current state, for debug
//   IllegalOp           sticky flag, set when an illegal opcode is decoded
//   InstrCount          retired-instruction counter, wraps
module multicycle_control
  import mc_pkg::*;
#(
  parameter int COUNT_WIDTH = 32,
  parameter bit ADDR_SEL_PC = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [5:0]             OP,
  input  logic [5:0]             Funct,
  input  logic                   MemReady,
  output logic                   PCWrite,
  output logic                   BranchEQ,
  output logic                   BranchNE,
  output logic                   IorD,
  output logic                   MemRead,
  output logic                   MemWrite,
  output logic                   IRWrite,
  output logic                   RegWrite,
  output logic [1:0]             RegDst,
  output logic [1:0]             MemtoReg,
  output logic                   ALUSrcA,
  output logic [2:0]             ALUSrcB,
  output logic [3:0]             ALUOp,
  output logic [1:0]             PCSource,
  output logic [3:0]             State,
  output logic                   IllegalOp,
  output logic [COUNT_WIDTH-1:0] InstrCount
);

  stateT state;
  stateT nextState;
  logic  retire;

  assign State = state;

  // State register: reset always restarts at FETCH, abandoning whatever
  // instruction was in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic. OP/Funct are only consulted in states where the IR
  // is already loaded. retire marks the last cycle of an instruction, i.e.
  // the cycle whose transition returns to FETCH.
  always_comb begin
    nextState = state;
    retire    = 1'b0;
    case (state)
      S_FETCH:   if (MemReady) nextState = S_DECODE;
      S_DECODE: begin
        case (OP)
          OP_LW, OP_SW:             nextState = S_MEMADR;
          OP_RTYPE:                 nextState = (Funct == FUNCT_JR) ? S_JR : S_RTEXEC;
          OP_BEQ, OP_BNE:           nextState = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI: nextState = S_IMMEXEC;
          OP_LUI:                   nextState = S_LUI;
          OP_J, OP_JAL:             nextState = S_JUMP;
          default:                  nextState = S_TRAP;
        endcase
      end
      S_MEMADR:  nextState = (OP == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (MemReady) nextState = S_MEMWB;
      S_MEMWR: begin
        if (MemReady) begin
          nextState = S_FETCH;
          retire    = 1'b1;
        end
      end
      S_RTEXEC:  nextState = S_RTWB;
      S_IMMEXEC: nextState = S_IMMWB;
      S_MEMWB, S_RTWB, S_BRANCH, S_IMMWB, S_JUMP, S_JR, S_LUI: begin
        nextState = S_FETCH;
        retire    = 1'b1;
      end
      S_TRAP:    nextState = S_TRAP;
      default:   nextState = S_TRAP;
    endcase
  end

  // Output decode. Mostly Moore; branch polarity, the immediate ALU mode
  // and jal's link write look at OP, and FETCH's PC/IR loads wait for
  // MemReady. Reset suppresses every strobe so nothing is written while
  // the core is held.
  always_comb begin
    PCWrite  = 1'b0;
    BranchEQ = 1'b0;
    BranchNE = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    RegDst   = REGDST_RT;
    MemtoReg = M2R_ALUOUT;
    ALUSrcA  = SRCA_PC;
    ALUSrcB  = SRCB_B;
    ALUOp    = ALU_ADD;
    PCSource = PCSRC_ALU;
    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        IorD    = ADDR_SEL_PC;
        ALUSrcB = SRCB_FOUR;
        PCWrite = MemReady;
        IRWrite = MemReady;
      end
      S_DECODE:  ALUSrcB = SRCB_SIGNSHL2;
      S_MEMADR: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_SIGNEXT;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = ~ADDR_SEL_PC;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = M2R_MDR;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = ~ADDR_SEL_PC;
      end
      S_RTEXEC: begin
        ALUSrcA = SRCA_A;
        ALUOp   = ALU_RTYPE;
      end
      S_RTWB: begin
        RegWrite = 1'b1;
        RegDst   = REGDST_RD;
      end
      S_BRANCH: begin
        ALUSrcA  = SRCA_A;
        ALUOp    = ALU_SUB;
        PCSource = PCSRC_ALUOUT;
        BranchEQ = (OP == OP_BEQ);
        BranchNE = (OP == OP_BNE);
      end
      S_IMMEXEC: begin
        ALUSrcA = SRCA_A;
        case (OP)
          OP_ADDI: ALUSrcB = SRCB_SIGNEXT;
          OP_ANDI: begin
            ALUSrcB = SRCB_ZEROEXT;
            ALUOp   = ALU_AND;
          end
          OP_ORI: begin
            ALUSrcB = SRCB_ZEROEXT;
            ALUOp   = ALU_OR;
          end
          default: ALUSrcB = SRCB_B;
        endcase
      end
      S_IMMWB:   RegWrite = 1'b1;
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
        // PC already advanced in FETCH, so it is the link value for jal
        if (OP == OP_JAL) begin
          RegWrite = 1'b1;
          RegDst   = REGDST_RA;
          MemtoReg = M2R_PC;
        end
      end
      S_JR: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_RS;
      end
      S_LUI: begin
        RegWrite = 1'b1;
        MemtoReg = M2R_LUI;
      end
      default: ;
    endcase
    if (reset) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      BranchEQ = 1'b0;
      BranchNE = 1'b0;
    end
  end

  // Trap flag and retired counter. The flag rises on the same edge that
  // enters TRAP so it lines up with the state; it is only cleared by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      IllegalOp  <= 1'b0;
      InstrCount <= '0;
    end else begin
      if (nextState == S_TRAP) begin
        IllegalOp <= 1'b1;
      end
      if (retire) begin
        InstrCount <= InstrCount + COUNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed bench for the multicycle control FSM.
// Each stimulus cycle pushes its hand-computed expected control word into
// a scoreboard queue; a monitor on the falling edge pops and compares.
module tb_multicycle_control;

  logic        clk;
  logic        reset;
  logic [5:0]  OP;
  logic [5:0]  Funct;
  logic        MemReady;
  logic        PCWrite, BranchEQ, BranchNE, IorD, MemRead, MemWrite;
  logic        IRWrite, RegWrite, ALUSrcA, IllegalOp;
  logic [1:0]  RegDst, MemtoReg, PCSource;
  logic [2:0]  ALUSrcB;
  logic [3:0]  ALUOp, State;
  logic [31:0] InstrCount;

  typedef struct {
    string       name;
    logic [26:0] ctl;
    logic [31:0] cnt;
  } expT;

  expT sb[$];
  int  checks = 0;
  int  errors = 0;

  multicycle_control #(.COUNT_WIDTH(32), .ADDR_SEL_PC(1'b0)) dut (
    .clk(clk), .reset(reset), .OP(OP), .Funct(Funct), .MemReady(MemReady),
    .PCWrite(PCWrite), .BranchEQ(BranchEQ), .BranchNE(BranchNE), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .State(State), .IllegalOp(IllegalOp),
    .InstrCount(InstrCount)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive the instruction fields and memory handshake
  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] funct,
                               input logic ready);
    OP       = op;
    Funct    = funct;
    MemReady = ready;
  endtask

  // Queue the expected control word for the current cycle, then move on.
  // strb order: PCWrite BranchEQ BranchNE MemRead MemWrite IRWrite RegWrite
  task automatic expectCycle(input string name, input logic [3:0] st,
                             input logic [6:0] strb, input logic iord,
                             input logic [1:0] regDst, input logic [1:0] m2r,
                             input logic srcA, input logic [2:0] srcB,
                             input logic [3:0] aluOp, input logic [1:0] pcSrc,
                             input logic ill, input logic [31:0] cnt);
    expT e;
    e.name = name;
    e.ctl  = {st, strb, iord, regDst, m2r, srcA, srcB, aluOp, pcSrc, ill};
    e.cnt  = cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic fetchCycle(input string name, input logic ready,
                            input logic [31:0] cnt);
    expectCycle(name, 4'd0, ready ? 7'b1001010 : 7'b0001000, 1'b0, 2'd0, 2'd0,
                1'b0, 3'd1, 4'd0, 2'd0, 1'b0, cnt);
  endtask

  task automatic decodeCycle(input string name, input logic [31:0] cnt);
    expectCycle(name, 4'd1, 7'b0, 1'b0, 2'd0, 2'd0, 1'b0, 3'd3, 4'd0, 2'd0,
                1'b0, cnt);
  endtask

  task automatic checkOutput(input expT e);
    logic [26:0] act;
    act = {State, PCWrite, BranchEQ, BranchNE, MemRead, MemWrite, IRWrite,
           RegWrite, IorD, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp,
           PCSource, IllegalOp};
    checks++;
    if (act !== e.ctl || InstrCount !== e.cnt) begin
      errors++;
      $display("[TB] FAIL %s: ctl got %h want %h, InstrCount got %0d want %0d",
               e.name, act, e.ctl, InstrCount, e.cnt);
    end
  endtask

  // Monitor: compare whatever control word the DUT presents mid-cycle
  initial begin
    expT cur;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        cur = sb.pop_front();
        checkOutput(cur);
      end
    end
  end

  initial begin
    reset = 1'b1;
    applyStimulus(6'b000000, 6'b000000, 1'b0);
    @(posedge clk);
    #1;

    // Power-up reset: FETCH selects, no strobes
    expectCycle("resetHold0", 4'd0, 7'b0, 1'b0, 2'd0, 2'd0, 1'b0, 3'd1, 4'd0, 2'd0, 1'b0, 0);
    expectCycle("resetHold1", 4'd0, 7'b0, 1'b0, 2'd0, 2'd0, 1'b0, 3'd1, 4'd0, 2'd0, 1'b0, 0);
    reset = 1'b0;

    // lw stalled in MEMRD, then abandoned by reset
    applyStimulus(6'b100011, 6'b000000, 1'b1);
    fetchCycle("abortFetch", 1'b1, 0);
    decodeCycle("abortDecode", 0);
    applyStimulus(6'b100011, 6'b000000, 1'b0);
    expectCycle("abortAdr", 4'd2, 7'b0, 1'b0, 2'd0, 2'd0, 1'b1, 3'd2, 4'd0, 2'd0, 1'b0, 0);
    expectCycle("abortRdWait", 4'd3, 7'b0001000, 1'b1, 2'd0, 2'd0, 1'b0, 3'd0, 4'd0, 2'd0, 1'b0, 0);
    reset = 1'b1;
    expectCycle("midRdReset0", 4'd0, 7'b0, 1'b0, 2'd0, 2'd0, 1'b0, 3'd1, 4'd0, 2'd0, 1'b0, 0);
    expectCycle("midRdReset1", 4'd0, 7'b0, 1'b0, 2'd0, 2'd0, 1'b0, 3'd1, 4'd0, 2'd0, 1'b0, 0);
    reset = 1'b0;

    // lw, memory always ready: 0,1,2,3,4
    applyStimulus(6'b100011, 6'b000000, 1'b1);
    fetchCycle("lwFetch", 1'b1, 0);
    decodeCycle("lwDecode", 0);
    expectCycle("lwAdr", 4'd2, 7'b0, 1'b0, 2'd0, 2'd0, 1'b1, 3'd2, 4'd0, 2'd0, 1'b0, 0);
    expectCycle("lwRead", 4'd3, 7'b0001000, 1'b1, 2'd0, 2'd0, 1'b0, 3'd0, 4'd0, 2'd0, 1'b0, 0);
    expectCycle("lwWb", 4'd4, 7'b0000001, 1'b0, 2'd0, 2'd1, 1'b0, 3'd0, 4'd0, 2'd0, 1'b0, 0);

    // sw with three wait cycles in MEMWR: 7 cycles total
    applyStimulus(6'b101011, 6'b000000, 1'b1);
    fetchCycle("swFetch", 1'b1, 1);
    decodeCycle("swDecode", 1);
    expectCycle("swAdr", 4'd2, 7'b0, 1'b0, 2'd0, 2'd0, 1'b1, 3'd2, 4'd0, 2'd0, 1'b0, 1);
    applyStimulus(6'b101011, 6'b000000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      expectCycle("swWait", 4'd5, 7'b0000100, 1'b1, 2'd0, 2'd0, 1'b0, 3'd0, 4'd0, 2'd0, 1'b0, 1);
    end
    applyStimulus(6'b101011, 6'b000000, 1'b1);
    expectCycle("swDone", 4'd5, 7'b0000100, 1'b1, 2'd0, 2'd0, 1'b0, 3'd0, 4'd0, 2'd0, 1'b0, 1);

    // add: 0,1,6,7
    applyStimulus(6'b000000, 6'b100000, 1'b1);
    fetchCycle("addFetch", 1'b1, 2);
    decodeCycle("addDecode", 2);
    expectCycle("addExec", 4'd6, 7'b0, 1'b0, 2'd0, 2'd0, 1'b1, 3'd0, 4'b0111, 2'd0, 1'b0, 2);
    expectCycle("addWb", 4'd7, 7'b0000001, 1'b0, 2'd1, 2'd0, 1'b0, 3'd0, 4'd0, 2'd0, 1'b0, 2);

    // jr: 0,1,12
    applyStimulus(6'b000000, 6'b001000, 1'b1);
    fetchCycle("jrFetch", 1'b1, 3);
    decodeCycle("jrDecode", 3);
    expectCycle("jrExec", 4'd12, 7'b1000000, 1'b0, 2'd0, 2'd0, 1'b0, 3'd0, 4'd0, 2'd3, 1'b0, 3);

    // beq then bne: only the matching branch strobe rises
    applyStimulus(6'b000100, 6'b000000, 1'b1);
    fetchCycle("beqFetch", 1'b1, 4);
    decodeCycle("beqDecode", 4);
    expectCycle("beqBranch", 4'd8, 7'b0100000, 1'b0, 2'd0, 2'd0, 1'b1, 3'd0, 4'b0001, 2'd1, 1'b0, 4);
    applyStimulus(6'b000101, 6'b000000, 1'b1);
    fetchCycle("bneFetch", 1'b1, 5);
    decodeCycle("bneDecode", 5);
    expectCycle("bneBranch", 4'd8, 7'b0010000, 1'b0, 2'd0, 2'd0, 1'b1, 3'd0, 4'b0001, 2'd1, 1'b0, 5);

    // jal: jump plus link write
    applyStimulus(6'b000011, 6'b000000, 1'b1);
    fetchCycle("jalFetch", 1'b1, 6);
    decodeCycle("jalDecode", 6);
    expectCycle("jalJump", 4'd11, 7'b1000001, 1'b0, 2'd2, 2'd2, 1'b0, 3'd0, 4'd0, 2'd2, 1'b0, 6);

    // ori: zero-extended immediate, OR
    applyStimulus(6'b001101, 6'b000000, 1'b1);
    fetchCycle("oriFetch", 1'b1, 7);
    decodeCycle("oriDecode", 7);
    expectCycle("oriExec", 4'd9, 7'b0, 1'b0, 2'd0, 2'd0, 1'b1, 3'd4, 4'b0010, 2'd0, 1'b0, 7);
    expectCycle("oriWb", 4'd10, 7'b0000001, 1'b0, 2'd0, 2'd0, 1'b0, 3'd0, 4'd0, 2'd0, 1'b0, 7);

    // lui: write imm<<16 to rt
    applyStimulus(6'b001111, 6'b000000, 1'b1);
    fetchCycle("luiFetch", 1'b1, 8);
    decodeCycle("luiDecode", 8);
    expectCycle("luiWb", 4'd13, 7'b0000001, 1'b0, 2'd0, 2'd3, 1'b0, 3'd0, 4'd0, 2'd0, 1'b0, 8);

    // Illegal opcode: TRAP held, counter frozen, cleared only by reset
    applyStimulus(6'b111111, 6'b000000, 1'b1);
    fetchCycle("illFetch", 1'b1, 9);
    decodeCycle("illDecode", 9);
    for (int i = 0; i < 20; i++) begin
      expectCycle("trapHold", 4'd14, 7'b0, 1'b0, 2'd0, 2'd0, 1'b0, 3'd0, 4'd0, 2'd0, 1'b1, 9);
    end
    reset = 1'b1;
    expectCycle("trapReset", 4'd0, 7'b0, 1'b0, 2'd0, 2'd0, 1'b0, 3'd1, 4'd0, 2'd0, 1'b0, 0);
    reset = 1'b0;
    fetchCycle("postTrapFetch", 1'b1, 0);

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d expected words left unchecked, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
